// File: rtl/block_map_gen_pkg.sv
// Shared tile codes, default grid size and FSM state encodings for the map generator.
// Used by block_map_gen, tile_classifier, and by the tile-map RAM and renderer.
// Pure declarations; no logic, no latency.
package block_map_gen_pkg;

    typedef logic [1:0] tile_t;

    localparam tile_t TILE_EMPTY = 2'd0;
    localparam tile_t TILE_SOFT  = 2'd1;
    localparam tile_t TILE_HARD  = 2'd2;

    localparam int DEF_COLS = 15;
    localparam int DEF_ROWS = 11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SEED  = 3'd1,
        ST_CALC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    function automatic logic [15:0] safe_seed(input logic [15:0] s);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/block_map_gen_tile_classifier.sv
// Classifies one grid cell as HARD (border/pillar), EMPTY (spawn zone) or SOFT/EMPTY by density.
// Purely combinational, zero latency.
// No flow control; result valid whenever inputs are.
module tile_classifier
    import block_map_gen_pkg::*;
#(
    parameter int COLS = DEF_COLS,
    parameter int ROWS = DEF_ROWS,
    parameter int XW   = $clog2(COLS),
    parameter int YW   = $clog2(ROWS)
) (
    input  logic [XW-1:0] x,
    input  logic [YW-1:0] y,
    input  logic [7:0]    rnd,
    input  logic [7:0]    density,
    output tile_t         code
);

    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
    localparam logic [XW-1:0] X_ONE  = XW'(1);
    localparam logic [XW-1:0] X_TWO  = XW'(2);
    localparam logic [YW-1:0] Y_ONE  = YW'(1);
    localparam logic [YW-1:0] Y_TWO  = YW'(2);

    logic border;
    logic pillar;
    logic spawn;

    assign border = (x == '0) || (x == X_LAST) || (y == '0) || (y == Y_LAST);
    assign pillar = !x[0] && !y[0];
    assign spawn  = ((x == X_ONE) && (y == Y_ONE)) ||
                    ((x == X_TWO) && (y == Y_ONE)) ||
                    ((x == X_ONE) && (y == Y_TWO));

    // Priority: hard structure first, then the guaranteed-empty spawn corner, then density.
    always_comb begin
        code = TILE_EMPTY;
        if (border || pillar) begin
            code = TILE_HARD;
        end else if (spawn) begin
            code = TILE_EMPTY;
        end else if ((density == 8'hFF) || (rnd < density)) begin
            code = TILE_SOFT;
        end
    end

endmodule

// File: rtl/block_map_gen.sv
// Level-start map generator: seeds the LFSR, then writes one tile code per cell in row-major order.
// Latency: done pulses 2 + 2*COLS*ROWS cycles after start when wr_ready is held high.
// Backpressure: wr_ready low holds wr_en/wr_addr/wr_data stable in WRITE; the LFSR keeps running.
module block_map_gen
    import block_map_gen_pkg::*;
#(
    parameter int COLS   = DEF_COLS,
    parameter int ROWS   = DEF_ROWS,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [15:0]       seed,
    input  logic [7:0]        density,
    input  logic [15:0]       lfsr_out,
    output logic              lfsr_w_en,
    output logic [15:0]       lfsr_w_in,
    output logic              wr_en,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output tile_t             wr_data,
    output logic              busy,
    output logic              done,
    output logic [7:0]        soft_count
);

    localparam int XW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

    state_t            state;
    state_t            state_nxt;
    logic [XW-1:0]     x;
    logic [YW-1:0]     y;
    logic [7:0]        den_q;
    tile_t             cls_code;
    logic [ADDR_W-1:0] cell_addr;
    logic              handshake;
    logic              last_x;
    logic              last_cell;

    // Only the low byte of the LFSR drives classification.
    logic unused_rnd_hi;
    assign unused_rnd_hi = ^lfsr_out[15:8];

    assign last_x    = (x == X_LAST);
    assign last_cell = last_x && (y == Y_LAST);
    assign handshake = (state == ST_WRITE) && wr_ready;
    assign cell_addr = ADDR_W'(y) * ADDR_W'(COLS) + ADDR_W'(x);

    tile_classifier #(
        .COLS (COLS),
        .ROWS (ROWS),
        .XW   (XW),
        .YW   (YW)
    ) u_classifier (
        .x       (x),
        .y       (y),
        .rnd     (lfsr_out[7:0]),
        .density (den_q),
        .code    (cls_code)
    );

    // Outputs are decoded straight from the state so they are all zero in IDLE/reset.
    assign lfsr_w_en = (state == ST_SEED);
    assign lfsr_w_in = lfsr_w_en ? safe_seed(seed) : 16'h0000;
    assign wr_en     = (state == ST_WRITE);
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; start is only honoured from IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_SEED;
            ST_SEED:  state_nxt = ST_CALC;
            ST_CALC:  state_nxt = ST_WRITE;
            ST_WRITE: if (wr_ready) state_nxt = last_cell ? ST_DONE : ST_CALC;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Cell cursor, density latch, write register and soft-tile counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x          <= '0;
            y          <= '0;
            den_q      <= '0;
            soft_count <= '0;
            wr_addr    <= '0;
            wr_data    <= TILE_EMPTY;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        den_q      <= density;
                        soft_count <= '0;
                        x          <= '0;
                        y          <= '0;
                    end
                end
                ST_CALC: begin
                    wr_data <= cls_code;
                    wr_addr <= cell_addr;
                end
                ST_WRITE: begin
                    if (handshake) begin
                        if (wr_data == TILE_SOFT) begin
                            soft_count <= soft_count + 8'd1;
                        end
                        if (last_x) begin
                            x <= '0;
                            y <= y + YW'(1);
                        end else begin
                            x <= x + XW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_block_map_gen.sv
// Self-checking bench for block_map_gen: a cycle-timeline model built from the generation rules
// predicts every output on every cycle; an LFSR behavioural model drives lfsr_out.
// Randomised seeds, densities and wr_ready stall patterns; mid-run start pulses and reset abort.
module tb_block_map_gen;

    localparam int COLS   = 15;
    localparam int ROWS   = 11;
    localparam int ADDR_W = 8;
    localparam int CELLS  = COLS * ROWS;
    localparam int MAXC   = 2000;

    logic              clk;
    logic              rst;
    logic              start;
    logic [15:0]       seed;
    logic [7:0]        density;
    logic [15:0]       lfsr_out;
    logic              lfsr_w_en;
    logic [15:0]       lfsr_w_in;
    logic              wr_en;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [1:0]        wr_data;
    logic              busy;
    logic              done;
    logic [7:0]        soft_count;

    int total = 0;
    int bad   = 0;

    block_map_gen #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .seed       (seed),
        .density    (density),
        .lfsr_out   (lfsr_out),
        .lfsr_w_en  (lfsr_w_en),
        .lfsr_w_in  (lfsr_w_in),
        .wr_en      (wr_en),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .soft_count (soft_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Galois LFSR, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Stand-in for the upstream LFSR: free-runs every cycle, loads on lfsr_w_en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            lfsr_out <= 16'hFFFF;
        else if (lfsr_w_en) lfsr_out <= lfsr_w_in;
        else                lfsr_out <= lfsr_step(lfsr_out);
    end

    // Expected per-cycle timeline (cycle 0 = cycle in which start is high).
    logic       e_wen  [MAXC];
    logic       e_done [MAXC];
    logic       e_busy [MAXC];
    logic       e_lw   [MAXC];
    logic [7:0] e_addr [MAXC];
    logic [1:0] e_dat  [MAXC];
    logic [7:0] e_sc   [MAXC];
    bit         rdy    [MAXC];
    bit         stp    [MAXC];
    logic [15:0] m_seed;
    int done_cyc, m_soft, prev_sc;

    logic [1:0] obs   [CELLS];
    logic [1:0] saved [CELLS];
    int n_wr, n_done, dut_done_k, o_hard, o_soft, o_empty;

    function automatic logic [1:0] ref_tile(input int x, input int y,
                                            input logic [7:0] rnd, input logic [7:0] den);
        if (x == 0 || x == COLS - 1 || y == 0 || y == ROWS - 1) return 2'd2;
        if ((x % 2 == 0) && (y % 2 == 0)) return 2'd2;
        if ((x == 1 && y == 1) || (x == 2 && y == 1) || (x == 1 && y == 2)) return 2'd0;
        if (den == 8'hFF || rnd < den) return 2'd1;
        return 2'd0;
    endfunction

    task automatic chk(input string name, input int k, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, k, act, exp);
        end
    endtask

    task automatic build_model(input logic [15:0] sd, input logic [7:0] den);
        logic [15:0] lv [MAXC];
        logic [1:0]  code;
        int t, c, sc;
        m_seed = (sd == 16'h0000) ? 16'h0001 : sd;
        for (int k = 0; k < MAXC; k++) begin
            e_wen[k] = 0; e_done[k] = 0; e_busy[k] = 0; e_lw[k] = 0;
            e_addr[k] = 0; e_dat[k] = 0; e_sc[k] = 0; lv[k] = 0;
        end
        lv[2] = m_seed;
        for (int k = 3; k < MAXC; k++) lv[k] = lfsr_step(lv[k-1]);
        e_sc[0] = 8'(prev_sc);
        e_busy[1] = 1; e_lw[1] = 1;
        t = 2; sc = 0;
        for (int i = 0; i < CELLS; i++) begin
            code = ref_tile(i % COLS, i / COLS, lv[t][7:0], den);
            e_busy[t] = 1; e_sc[t] = 8'(sc);
            c = t;
            do begin
                c++;
                e_wen[c] = 1; e_busy[c] = 1; e_addr[c] = 8'(i); e_dat[c] = code; e_sc[c] = 8'(sc);
            end while (!rdy[c]);
            if (code == 2'd1) sc++;
            t = c + 1;
        end
        e_done[t] = 1; e_busy[t] = 1; e_sc[t] = 8'(sc); e_sc[t+1] = 8'(sc);
        done_cyc = t;
        m_soft = sc;
    endtask

    task automatic check_cycle(input int k);
        chk("ctl", k, 16'({busy, done, wr_en, lfsr_w_en}),
            16'({e_busy[k], e_done[k], e_wen[k], e_lw[k]}));
        if (e_wen[k]) begin
            chk("wr_addr", k, 16'(wr_addr), 16'(e_addr[k]));
            chk("wr_data", k, 16'(wr_data), 16'(e_dat[k]));
        end
        if (e_lw[k]) chk("lfsr_w_in", k, lfsr_w_in, m_seed);
        chk("soft_count", k, 16'(soft_count), 16'(e_sc[k]));
    endtask

    task automatic run(input logic [15:0] sd, input logic [7:0] den, input int pct,
                       input int abort_addr, input bit pulses, output bit aborted);
        aborted = 0;
        for (int k = 0; k < MAXC; k++) begin
            rdy[k] = (k >= MAXC - 400) ? 1'b1 : ($urandom_range(0, 99) < pct);
            stp[k] = 0;
        end
        build_model(sd, den);
        if (pulses) begin
            stp[3] = 1; stp[100] = 1; stp[done_cyc] = 1;
        end
        for (int i = 0; i < CELLS; i++) obs[i] = 2'd3;
        n_wr = 0; n_done = 0; dut_done_k = -1;
        for (int k = 0; k <= done_cyc + 1; k++) begin
            @(negedge clk);
            start    = (k == 0) || stp[k];
            density  = (k == 0) ? den : 8'($urandom);
            seed     = sd;
            wr_ready = rdy[k];
            if (abort_addr >= 0 && e_wen[k] && int'(e_addr[k]) == abort_addr) begin
                rst = 1'b1;
                #1;
                chk("abort_wr_en", k, 16'(wr_en), 16'd0);
                chk("abort_busy", k, 16'(busy), 16'd0);
                chk("abort_soft_count", k, 16'(soft_count), 16'd0);
                @(negedge clk);
                rst = 1'b0; start = 1'b0; wr_ready = 1'b0;
                prev_sc = 0;
                aborted = 1;
                return;
            end
            check_cycle(k);
            if (wr_en && wr_ready) begin
                n_wr++;
                if (int'(wr_addr) < CELLS) obs[wr_addr] = wr_data;
            end
            if (done) begin
                n_done++;
                if (dut_done_k < 0) dut_done_k = k;
            end
        end
        start = 1'b0;
        prev_sc = m_soft;
        o_hard = 0; o_soft = 0; o_empty = 0;
        for (int i = 0; i < CELLS; i++) begin
            if (obs[i] == 2'd2) o_hard++;
            else if (obs[i] == 2'd1) o_soft++;
            else if (obs[i] == 2'd0) o_empty++;
        end
    endtask

    initial begin
        bit ab;
        int diffs;
        logic [15:0] s5;
        logic [7:0]  d5;
        rst = 1'b1; start = 1'b0; seed = 16'h0; density = 8'h0; wr_ready = 1'b0; prev_sc = 0;
        repeat (2) @(negedge clk);
        chk("rst_ctl", 0, 16'({busy, done, wr_en, lfsr_w_en}), 16'd0);
        chk("rst_wr_addr", 0, 16'(wr_addr), 16'd0);
        chk("rst_wr_data", 0, 16'(wr_data), 16'd0);
        chk("rst_soft_count", 0, 16'(soft_count), 16'd0);
        chk("rst_lfsr_w_in", 0, lfsr_w_in, 16'd0);
        rst = 1'b0;

        // Density 0: only hard blocks and empties; fixed latency.
        run(16'hACE1, 8'h00, 100, -1, 0, ab);
        chk("d0_model_done_cyc", 0, 16'(done_cyc), 16'd332);
        chk("d0_dut_done_cyc", 0, 16'(dut_done_k), 16'd332);
        chk("d0_hard", 0, 16'(o_hard), 16'd72);
        chk("d0_empty", 0, 16'(o_empty), 16'd93);
        chk("d0_soft", 0, 16'(o_soft), 16'd0);
        chk("d0_writes", 0, 16'(n_wr), 16'd165);

        // Density FF: everything soft except the spawn corner.
        run(16'($urandom), 8'hFF, 100, -1, 0, ab);
        chk("dff_hard", 0, 16'(o_hard), 16'd72);
        chk("dff_soft", 0, 16'(o_soft), 16'd90);
        chk("dff_empty16", 0, 16'(obs[16]), 16'd0);
        chk("dff_empty17", 0, 16'(obs[17]), 16'd0);
        chk("dff_empty31", 0, 16'(obs[31]), 16'd0);
        chk("dff_soft_count_held", 0, 16'(soft_count), 16'd90);

        // Zero seed is replaced by 1.
        run(16'h0000, 8'h80, 100, -1, 0, ab);
        chk("s0_writes", 0, 16'(n_wr), 16'd165);

        // ~50% stalls plus start pulses while busy.
        run(16'($urandom), 8'($urandom), 50, -1, 1, ab);
        chk("stall_done_pulses", 0, 16'(n_done), 16'd1);
        chk("stall_writes", 0, 16'(n_wr), 16'd165);

        // Reset at address 40, then identical regeneration.
        s5 = 16'h1D2B; d5 = 8'h60;
        run(s5, d5, 100, -1, 0, ab);
        for (int i = 0; i < CELLS; i++) saved[i] = obs[i];
        run(s5, d5, 100, 40, 0, ab);
        chk("abort_taken", 0, 16'(ab), 16'd1);
        @(negedge clk);
        chk("abort_idle_wr_en", 0, 16'(wr_en), 16'd0);
        run(s5, d5, 100, -1, 0, ab);
        diffs = 0;
        for (int i = 0; i < CELLS; i++) if (obs[i] !== saved[i]) diffs++;
        chk("rerun_identical", 0, 16'(diffs), 16'd0);

        for (int r = 0; r < 3; r++) begin
            run(16'($urandom), 8'($urandom), 70, -1, 0, ab);
            chk("rand_writes", r, 16'(n_wr), 16'd165);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/block_map_gen.md
Name: block_map_gen

Overview:
- Level-start map generator for the Bomberman playfield.
- Sits directly downstream of the team's 16-bit LFSR. It seeds the LFSR through its write port, consumes its output, and writes one 2-bit tile code per grid cell into the tile-map RAM.
- Borders and pillars are always hard blocks. The spawn corner is always empty. Every other cell becomes a soft (destructible) block according to a density threshold.

Parameters:
- COLS, 15, grid width in tiles.
- ROWS, 11, grid height in tiles.
- ADDR_W, 8, tile-map address width; must satisfy 2^ADDR_W >= COLS*ROWS.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  one-cycle request to generate a new map
- seed  in  16  LFSR seed for this level
- density  in  8  soft-block threshold
- lfsr_out  in  16  current LFSR value
- lfsr_w_en  out  1  LFSR load strobe
- lfsr_w_in  out  16  LFSR load value
- wr_en  out  1  tile write request
- wr_ready  in  1  RAM accepts the write this cycle
- wr_addr  out  ADDR_W  tile address = y*COLS + x
- wr_data  out  2  tile code
- busy  out  1  generation in progress
- done  out  1  one-cycle completion pulse
- soft_count  out  8  number of SOFT tiles written this run

Behaviour:
- Reset and clock: rst asynchronous, active-high; clk rising edge. All state is in the clk domain.
- Reset values: state=IDLE; x=0, y=0; every output 0; soft_count=0; density latch=0.
- Tile codes: 0 EMPTY, 1 SOFT, 2 HARD, 3 unused (never written).
- Classification for cell (x,y), rnd = lfsr_out[7:0] sampled in CALC:
  - HARD if x==0, x==COLS-1, y==0 or y==ROWS-1 (border).
  - HARD if x and y are both even (pillar).
  - EMPTY if (x,y) is (1,1), (2,1) or (1,2) (spawn safe zone).
  - Otherwise SOFT if density==8'hFF or rnd < density; else EMPTY.
- FSM states and transitions:
  - IDLE: start=1 -> latch density, clear soft_count, set x=y=0 -> SEED. start is ignored in every other state.
  - SEED: lfsr_w_en=1 for exactly this cycle. lfsr_w_in=seed, or 16'h0001 if seed==0. -> CALC.
  - CALC: classify (x,y) from the live lfsr_out. Register wr_data and wr_addr. -> WRITE.
  - WRITE: wr_en=1; wr_addr and wr_data held stable.
    - On wr_ready=1 (handshake): increment soft_count if the code is SOFT; advance x, wrapping at COLS-1 to 0 with y+1.
    - If the handshake was for the last cell (x=COLS-1, y=ROWS-1) -> DONE, else -> CALC.
    - On wr_ready=0: stay in WRITE.
  - DONE: done=1 for one cycle; soft_count held until the next start. -> IDLE.
- busy: 1 in SEED, CALC, WRITE and DONE; 0 only in IDLE.
- Latency: with wr_ready tied to 1, done asserts 2 + 2*COLS*ROWS cycles after the start cycle (332 for 15x11).
- LFSR advances every cycle, including stall cycles. The map is therefore a deterministic function of (seed, density, wr_ready pattern).
- Writes are strictly in row-major order. No address is repeated or skipped.
- rst mid-run: immediate return to IDLE, wr_en deasserted, no further writes.

Decomposition:
- Shared package/header holds TILE_EMPTY, TILE_SOFT, TILE_HARD, the default COLS/ROWS and the state encodings. The tile-map RAM and renderer use the same constants.
- One natural sub-module: tile_classifier (combinational). Inputs x, y, rnd, density; output tile code. Reused by a later block-respawn feature.
- The FSM and counters stay in block_map_gen.

Test Plan:
- density=0, seed=16'hACE1, wr_ready=1 -> 165 writes to addr 0..164; 72 HARD, 93 EMPTY; soft_count=0; done at cycle 332 after start.
- density=8'hFF -> 72 HARD, 3 EMPTY at addr 16, 17, 31; soft_count=90.
- seed=0 -> lfsr_w_in=16'h0001 during SEED. Classification across the run matches a reference model seeded with 1.
- wr_ready randomly deasserted (~50%) -> wr_addr and wr_data stable while stalled; no duplicate or missing addresses; output matches a model that advances the LFSR every cycle.
- start pulsed again while busy -> ignored; single run completes with exactly one done pulse.
- rst asserted at addr 40 -> wr_en=0, busy=0 immediately. A new start then regenerates from addr 0 with identical output for the same seed.
